// File: rtl/axi_read_latency_timer.sv
// Times single-outstanding AXI4 reads from AR handshake to RLAST handshake by driving an
// external enable/load counter, and keeps latency min/max/count statistics.
module axi_read_latency_timer #(
    parameter int COUNT_SIZE = 32,
    parameter int STAT_SIZE  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    input  logic                  i_arvalid,
    input  logic                  i_arready,
    input  logic                  i_rvalid,
    input  logic                  i_rready,
    input  logic                  i_rlast,
    output logic                  o_cnt_enable,
    output logic                  o_cnt_load,
    output logic [COUNT_SIZE-1:0] o_cnt_load_value,
    input  logic [COUNT_SIZE-1:0] i_cnt_count,
    input  logic                  i_cnt_overflow,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [COUNT_SIZE-1:0] o_latency,
    output logic                  o_lat_overflow,
    output logic [COUNT_SIZE-1:0] o_min_latency,
    output logic [COUNT_SIZE-1:0] o_max_latency,
    output logic [STAT_SIZE-1:0]  o_txn_count,
    output logic [STAT_SIZE-1:0]  o_missed_count,
    output logic                  o_protocol_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_next;
    logic   ar_hs, r_end;
    logic   start, complete, missed, proto_err;
    logic   cnt_sat;
    logic [COUNT_SIZE-1:0] lat_value;

    function automatic logic [STAT_SIZE-1:0] sat_inc(input logic [STAT_SIZE-1:0] v);
        return (&v) ? v : v + STAT_SIZE'(1);
    endfunction

    // The counter holds (cycles - 1) at the RLAST cycle; a wrap or an all-ones count
    // means the true latency no longer fits, so report all-ones.
    function automatic logic [COUNT_SIZE-1:0] sat_latency(input logic [COUNT_SIZE-1:0] cnt,
                                                          input logic sat);
        return sat ? '1 : cnt + COUNT_SIZE'(1);
    endfunction

    assign ar_hs     = i_arvalid & i_arready;
    assign r_end     = i_rvalid & i_rready & i_rlast;
    assign cnt_sat   = i_cnt_overflow | (&i_cnt_count);
    assign lat_value = sat_latency(i_cnt_count, cnt_sat);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        complete   = 1'b0;
        missed     = 1'b0;
        proto_err  = 1'b0;
        case (state)
            IDLE: begin
                proto_err = r_end;
                if (ar_hs) begin
                    start      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (r_end) begin
                    complete = 1'b1;
                    if (ar_hs) start      = 1'b1;
                    else       state_next = IDLE;
                end else if (ar_hs) begin
                    missed = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Enable wins over load in the counter, so a restart must drop enable to reload.
    assign o_cnt_load       = rst_n & start;
    assign o_cnt_enable     = rst_n & (state == BUSY) & ~start;
    assign o_cnt_load_value = '0;
    assign o_busy           = (state == BUSY);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_done         <= 1'b0;
            o_latency      <= '0;
            o_lat_overflow <= 1'b0;
            o_min_latency  <= '1;
            o_max_latency  <= '0;
            o_txn_count    <= '0;
            o_missed_count <= '0;
            o_protocol_err <= 1'b0;
        end else begin
            o_done <= complete;
            if (complete) begin
                o_latency      <= lat_value;
                o_lat_overflow <= cnt_sat;
            end
            if (i_clear) begin
                o_min_latency  <= '1;
                o_max_latency  <= '0;
                o_txn_count    <= '0;
                o_missed_count <= '0;
                o_protocol_err <= 1'b0;
            end else begin
                if (complete) begin
                    if (lat_value < o_min_latency) o_min_latency <= lat_value;
                    if (lat_value > o_max_latency) o_max_latency <= lat_value;
                    o_txn_count <= sat_inc(o_txn_count);
                end
                if (missed)    o_missed_count <= sat_inc(o_missed_count);
                if (proto_err) o_protocol_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_read_latency_timer.sv
// Randomized and directed bench for axi_read_latency_timer with a companion counter model
// and a cycle-number based reference of read latency and statistics.
module tb_axi_read_latency_timer;

    localparam int CW = 6;
    localparam int SW = 4;
    localparam longint LAT_ONES  = (longint'(1) << CW) - 1;
    localparam longint STAT_ONES = (longint'(1) << SW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_clear = 1'b0;
    logic          i_arvalid = 1'b0, i_arready = 1'b0;
    logic          i_rvalid = 1'b0, i_rready = 1'b0, i_rlast = 1'b0;
    logic          o_cnt_enable, o_cnt_load;
    logic [CW-1:0] o_cnt_load_value;
    logic [CW-1:0] cnt = '0;
    logic          cnt_ovf = 1'b0;
    logic          o_busy, o_done, o_lat_overflow, o_protocol_err;
    logic [CW-1:0] o_latency, o_min_latency, o_max_latency;
    logic [SW-1:0] o_txn_count, o_missed_count;

    int n_checks = 0;
    int n_fail   = 0;

    axi_read_latency_timer #(.COUNT_SIZE(CW), .STAT_SIZE(SW)) dut (
        .clk(clk), .rst_n(rst_n), .i_clear(i_clear),
        .i_arvalid(i_arvalid), .i_arready(i_arready),
        .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rlast(i_rlast),
        .o_cnt_enable(o_cnt_enable), .o_cnt_load(o_cnt_load),
        .o_cnt_load_value(o_cnt_load_value),
        .i_cnt_count(cnt), .i_cnt_overflow(cnt_ovf),
        .o_busy(o_busy), .o_done(o_done), .o_latency(o_latency),
        .o_lat_overflow(o_lat_overflow), .o_min_latency(o_min_latency),
        .o_max_latency(o_max_latency), .o_txn_count(o_txn_count),
        .o_missed_count(o_missed_count), .o_protocol_err(o_protocol_err)
    );

    always #5 clk = ~clk;

    // companion enable/load/overflow up-counter; enable has priority over load
    always @(posedge clk) begin
        if (o_cnt_enable) begin
            cnt <= cnt + 1'b1;
            if (&cnt) cnt_ovf <= 1'b1;
        end else if (o_cnt_load) begin
            cnt     <= o_cnt_load_value;
            cnt_ovf <= 1'b0;
        end
    end

    // reference: a read in flight is remembered by the cycle number of its AR handshake
    longint cyc = 0;
    bit     m_inflight = 0;
    longint m_start = 0;
    bit     m_done = 0, m_ovf = 0, m_err = 0;
    longint m_lat = 0, m_min = LAT_ONES, m_max = 0, m_txn = 0, m_missed = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step(input bit ar, input bit re, input bit clr, input bit rn);
        longint len;
        bit     fin, miss, err, st;
        if (!rn) begin
            m_inflight = 0; m_done = 0; m_lat = 0; m_ovf = 0;
            m_min = LAT_ONES; m_max = 0; m_txn = 0; m_missed = 0; m_err = 0;
            return;
        end
        fin  = m_inflight && re;
        miss = m_inflight && ar && !re;
        err  = !m_inflight && re;
        st   = ar && (!m_inflight || re);
        m_done = fin;
        if (fin) begin
            len   = cyc - m_start;
            m_ovf = (len > LAT_ONES);
            m_lat = m_ovf ? LAT_ONES : len;
        end
        if (clr) begin
            m_min = LAT_ONES; m_max = 0; m_txn = 0; m_missed = 0; m_err = 0;
        end else begin
            if (fin) begin
                if (m_lat < m_min) m_min = m_lat;
                if (m_lat > m_max) m_max = m_lat;
                if (m_txn < STAT_ONES) m_txn++;
            end
            if (miss && m_missed < STAT_ONES) m_missed++;
            if (err) m_err = 1;
        end
        if (st) begin
            m_inflight = 1;
            m_start    = cyc;
        end else if (fin) begin
            m_inflight = 0;
        end
    endtask

    // One bus cycle: drive, check combinational counter drive, clock, check registers.
    task automatic cycle(input bit ar, input bit re, input bit clr, input bit rn);
        logic [2:0] rbits;
        logic [1:0] abits;
        if (ar) abits = 2'b11;
        else    do abits = 2'($urandom); while (abits == 2'b11);
        if (re) rbits = 3'b111;
        else    do rbits = 3'($urandom); while (rbits == 3'b111);
        {i_arvalid, i_arready}        = abits;
        {i_rvalid, i_rready, i_rlast} = rbits;
        i_clear = clr;
        rst_n   = rn;
        #1;
        check("cnt_load", o_cnt_load, rn && ar && (!m_inflight || re));
        check("cnt_enable", o_cnt_enable, rn && m_inflight && !(ar && re));
        check("cnt_load_value", o_cnt_load_value, 0);
        model_step(ar, re, clr, rn);
        @(posedge clk);
        #1;
        cyc++;
        check("busy", o_busy, m_inflight);
        check("done", o_done, m_done);
        check("latency", o_latency, m_lat);
        check("lat_overflow", o_lat_overflow, m_ovf);
        check("min_latency", o_min_latency, m_min);
        check("max_latency", o_max_latency, m_max);
        check("txn_count", o_txn_count, m_txn);
        check("missed_count", o_missed_count, m_missed);
        check("protocol_err", o_protocol_err, m_err);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 1);
    endtask

    initial begin
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("rst_min", o_min_latency, LAT_ONES);
        check("rst_done", o_done, 0);

        // basic measurement: latency 5
        idle(3);
        cycle(1, 0, 0, 1);
        idle(4);
        cycle(0, 1, 0, 1);
        check("basic_done", o_done, 1);
        check("basic_lat", o_latency, 5);
        check("basic_txn", o_txn_count, 1);

        // minimum latency then latency 7
        cycle(0, 0, 1, 1);
        cycle(1, 0, 0, 1);
        cycle(0, 1, 0, 1);
        check("min_lat", o_latency, 1);
        cycle(1, 0, 0, 1);
        idle(6);
        cycle(0, 1, 0, 1);
        check("min_stat", o_min_latency, 1);
        check("max_stat", o_max_latency, 7);
        check("two_txn", o_txn_count, 2);

        // back-to-back restart: latencies 8 then 3
        cycle(1, 0, 0, 1);
        idle(7);
        cycle(1, 1, 0, 1);
        check("restart_lat", o_latency, 8);
        check("restart_busy", o_busy, 1);
        idle(2);
        cycle(0, 1, 0, 1);
        check("restart_lat2", o_latency, 3);

        // missed read during a latency-8 read
        cycle(0, 0, 1, 1);
        cycle(1, 0, 0, 1);
        idle(1);
        cycle(1, 0, 0, 1);
        idle(5);
        cycle(0, 1, 0, 1);
        check("missed_cnt", o_missed_count, 1);
        check("missed_lat", o_latency, 8);

        // saturation, then a short read clears the overflow flag
        cycle(1, 0, 0, 1);
        idle(75);
        cycle(0, 1, 0, 1);
        check("sat_lat", o_latency, LAT_ONES);
        check("sat_ovf", o_lat_overflow, 1);
        cycle(1, 0, 0, 1);
        idle(2);
        cycle(0, 1, 0, 1);
        check("unsat_lat", o_latency, 3);
        check("unsat_ovf", o_lat_overflow, 0);

        // protocol error, clear coincident with done, reset mid-read
        idle(1);
        cycle(0, 1, 0, 1);
        check("proto_err", o_protocol_err, 1);
        cycle(1, 0, 0, 1);
        idle(1);
        cycle(0, 1, 1, 1);
        check("clr_lat", o_latency, 2);
        check("clr_txn", o_txn_count, 0);
        check("clr_err", o_protocol_err, 0);
        cycle(1, 0, 0, 1);
        idle(3);
        cycle(0, 0, 0, 0);
        check("rst_busy", o_busy, 0);
        idle(2);
        cycle(0, 1, 0, 1);
        check("rst_no_done", o_done, 0);

        // randomized traffic with phases of short and very long reads
        for (int ph = 0; ph < 8; ph++) begin
            int p_ar, p_re;
            p_ar = $urandom_range(5, 60);
            p_re = (ph % 3 == 2) ? 1 : $urandom_range(5, 60);
            for (int i = 0; i < 500; i++) begin
                cycle($urandom_range(0, 99) < p_ar, $urandom_range(0, 99) < p_re,
                      $urandom_range(0, 199) == 0, $urandom_range(0, 399) != 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
